// File: rtl/gate_seq_checker_if.sv
// Bundle of signals between gate_seq_checker and the gate under test.
//   start     : request one truth-table sweep (environment -> checker)
//   op        : gate-under-test output (environment -> checker)
//   input1/2  : operands driven to the gate under test (checker -> environment)
//   busy      : sweep in progress
//   done      : one-cycle pulse at sweep completion
//   pass      : last completed sweep had no mismatches
//   fail_mask : bit k set when vector k mismatched
interface gate_seq_checker_if;
  logic       start;
  logic       op;
  logic       input1;
  logic       input2;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] fail_mask;

  // Checker side.
  modport master (
    input  start,
    input  op,
    output input1,
    output input2,
    output busy,
    output done,
    output pass,
    output fail_mask
  );

  // Environment / gate-under-test side.
  modport slave (
    output start,
    output op,
    input  input1,
    input  input2,
    input  busy,
    input  done,
    input  pass,
    input  fail_mask
  );
endinterface

// File: rtl/gate_seq_checker.sv
// Drives the four operand combinations (0,0),(1,0),(0,1),(1,1) into a 2-input gate,
// holds each for SETTLE cycles plus one sample cycle, compares op against EXPECTED[k]
// on the edge ending the sample cycle, and reports per-vector mismatches.
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : gate_seq_checker_if.master (start, op in; input1, input2, busy, done,
//         pass, fail_mask out)
module gate_seq_checker #(
  parameter int unsigned SETTLE   = 1,       // legal range 1..15
  parameter logic [3:0]  EXPECTED = 4'b1110  // bit k = expected op for vector k
) (
  input logic               clk,
  input logic               rst,
  gate_seq_checker_if.master bus
);

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StSample,
    StDone
  } state_e;

  // Counter counts down to zero, so DRIVE lasts SETTLE cycles.
  localparam logic [3:0] SettleLoad = 4'(SETTLE - 1);

  state_e     state_q, state_d;
  logic [1:0] k_q, k_d;
  logic [3:0] cnt_q, cnt_d;
  logic       pass_q, pass_d;
  logic [3:0] mask_q, mask_d;
  logic       busy;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    mask_d  = mask_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StDrive;
          k_d     = 2'd0;
          cnt_d   = SettleLoad;
          mask_d  = 4'b0000;
          pass_d  = 1'b0;
        end
      end
      StDrive: begin
        if (cnt_q == 4'd0) begin
          state_d = StSample;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StSample: begin
        if (bus.op != EXPECTED[k_q]) begin
          mask_d[k_q] = 1'b1;
        end
        if (k_q == 2'd3) begin
          state_d = StDone;
          // Include the final sample in the verdict.
          pass_d  = (mask_d == 4'b0000);
        end else begin
          state_d = StDrive;
          k_d     = k_q + 2'd1;
          cnt_d   = SettleLoad;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      k_q     <= 2'd0;
      cnt_q   <= 4'd0;
      pass_q  <= 1'b0;
      mask_q  <= 4'b0000;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
      mask_q  <= mask_d;
    end
  end

  assign busy = (state_q == StDrive) || (state_q == StSample);

  // Operands follow k only while sweeping; k is stable across DRIVE+SAMPLE.
  assign bus.input1    = busy & k_q[0];
  assign bus.input2    = busy & k_q[1];
  assign bus.busy      = busy;
  assign bus.done      = (state_q == StDone);
  assign bus.pass      = pass_q;
  assign bus.fail_mask = mask_q;

endmodule

// File: tb/tb_gate_seq_checker.sv
module tb_gate_seq_checker;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gate_seq_checker_if bus0 ();
  gate_seq_checker_if bus1 ();

  gate_seq_checker #(.SETTLE(1)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  gate_seq_checker #(.SETTLE(3)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

  typedef struct {
    int         inst;
    logic [3:0] mask;
    logic       pass;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         pos[2]   = '{-1, -1};  // cycle index within a sweep, -1 when idle
  logic [3:0] mask_m[2] = '{4'b0000, 4'b0000};
  logic       pass_m[2] = '{1'b0, 1'b0};
  int         mode[2]   = '{0, 0};   // 0 OR,1 AND,2 tie0,3 tie1,4 noisy OR,5 XOR
  bit         pend[2]   = '{1'b0, 1'b0};
  logic       pend_pass[2];
  bit         checking  = 1'b0;
  logic [3:0] exp_tab   = 4'b1110;

  logic       in1_w[2], in2_w[2], busy_w[2], done_w[2], pass_w[2], start_w[2];
  logic [3:0] mask_w[2];
  assign in1_w[0] = bus0.input1;  assign in1_w[1] = bus1.input1;
  assign in2_w[0] = bus0.input2;  assign in2_w[1] = bus1.input2;
  assign busy_w[0] = bus0.busy;   assign busy_w[1] = bus1.busy;
  assign done_w[0] = bus0.done;   assign done_w[1] = bus1.done;
  assign pass_w[0] = bus0.pass;   assign pass_w[1] = bus1.pass;
  assign mask_w[0] = bus0.fail_mask; assign mask_w[1] = bus1.fail_mask;
  assign start_w[0] = bus0.start; assign start_w[1] = bus1.start;

  function automatic int settle(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  // Truth table of the modelled gate for operand index idx = input1 + 2*input2.
  function automatic logic gate(input int m, input int idx);
    logic a, b;
    a = idx[0];
    b = idx[1];
    case (m)
      0, 4:    return a | b;
      1:       return a & b;
      2:       return 1'b0;
      3:       return 1'b1;
      default: return a ^ b;
    endcase
  endfunction

  task automatic check(input string name, input int i, input logic [31:0] act,
                       input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s inst%0d t=%0t: got %0h, required %0h", name, i, $time, act, req);
    end
  endtask

  // Reference model: advances once per rising edge from start/rst alone.
  initial forever begin
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      int s, l, k;
      logic [3:0] em;
      s = settle(i) + 1;
      l = 4 * s;
      if (rst) begin
        pos[i]    = -1;
        mask_m[i] = 4'b0000;
        pass_m[i] = 1'b0;
        pend[i]   = 1'b0;
        for (int j = sb.size() - 1; j >= 0; j--) begin
          if (sb[j].inst == i) sb.delete(j);
        end
      end else if (pos[i] == -1) begin
        if (start_w[i] === 1'b1) begin
          pos[i]    = 1;
          mask_m[i] = 4'b0000;
          pass_m[i] = 1'b0;
          em = 4'b0000;
          for (int kk = 0; kk < 4; kk++) em[kk] = (gate(mode[i], kk) != exp_tab[kk]);
          sb.push_back('{inst: i, mask: em, pass: (em == 4'b0000)});
        end
      end else if (pos[i] == l + 1) begin
        pos[i] = -1;
      end else begin
        if (pos[i] % s == 0) begin
          k = (pos[i] - 1) / s;
          if (gate(mode[i], k) != exp_tab[k]) mask_m[i][k] = 1'b1;
        end
        pos[i]++;
        if (pos[i] == l + 1) pass_m[i] = (mask_m[i] == 4'b0000);
      end
    end
  end

  // Gate under test: op from the current operands; noisy mode randomises op
  // outside the sample cycles.
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      int s, l, idx;
      logic v;
      s   = settle(i) + 1;
      l   = 4 * s;
      idx = int'(in1_w[i]) + 2 * int'(in2_w[i]);
      if (mode[i] == 4 && !(pos[i] >= 1 && pos[i] <= l && pos[i] % s == 0)) begin
        v = 1'($urandom % 2);
      end else begin
        v = gate(mode[i], idx);
      end
      if (i == 0) bus0.op = v;
      else        bus1.op = v;
    end
  end

  // Monitor: cycle-level output checks plus scoreboard pop on done.
  initial forever begin
    @(negedge clk);
    if (checking) begin
      for (int i = 0; i < 2; i++) begin
        int s, l, k, idx;
        logic eb;
        s  = settle(i) + 1;
        l  = 4 * s;
        eb = (pos[i] >= 1) && (pos[i] <= l);
        k  = eb ? (pos[i] - 1) / s : 0;
        check("busy", i, 32'(busy_w[i]), 32'(eb));
        check("done", i, 32'(done_w[i]), 32'(pos[i] == l + 1));
        check("input1", i, 32'(in1_w[i]), eb ? 32'(k % 2) : 32'd0);
        check("input2", i, 32'(in2_w[i]), eb ? 32'(k / 2) : 32'd0);
        check("fail_mask_track", i, 32'(mask_w[i]), 32'(mask_m[i]));
        if (pos[i] != l + 1) check("pass_track", i, 32'(pass_w[i]), 32'(pass_m[i]));
        if (pend[i]) begin
          check("sb_pass", i, 32'(pass_w[i]), 32'(pend_pass[i]));
          pend[i] = 1'b0;
        end
        if (done_w[i] === 1'b1) begin
          idx = -1;
          for (int j = 0; j < sb.size(); j++) begin
            if (sb[j].inst == i && idx < 0) idx = j;
          end
          check("sb_done_expected", i, 32'(idx >= 0), 32'd1);
          if (idx >= 0) begin
            check("sb_fail_mask", i, 32'(mask_w[i]), 32'(sb[idx].mask));
            pend[i]      = 1'b1;
            pend_pass[i] = sb[idx].pass;
            sb.delete(idx);
          end
        end
      end
    end
  end

  task automatic set_start(input int i, input logic v);
    if (i == 0) bus0.start = v;
    else        bus1.start = v;
  endtask

  task automatic pulse_start(input int i, input int width);
    set_start(i, 1'b1);
    repeat (width) @(negedge clk);
    set_start(i, 1'b0);
  endtask

  task automatic wait_idle(input int i);
    int n;
    n = 0;
    while (pos[i] != -1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", i, 32'(pos[i] == -1), 32'd1);
    @(negedge clk);
  endtask

  task automatic run(input int i, input int m);
    mode[i] = m;
    pulse_start(i, 1);
    wait_idle(i);
  endtask

  initial begin
    rst        = 1'b1;
    bus0.start = 1'b0;
    bus1.start = 1'b0;
    repeat (3) @(negedge clk);
    checking = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run(0, 0);  // OR, pass
    run(0, 2);  // tie0 -> 1110
    run(0, 3);  // tie1 -> 0001
    run(0, 1);  // AND  -> 0110
    run(0, 4);  // op noise outside sample cycles
    run(0, 5);  // XOR  -> 1000

    // Re-pulse start during SAMPLE of k=1.
    mode[0] = 0;
    pulse_start(0, 1);
    repeat (3) @(negedge clk);
    pulse_start(0, 1);
    wait_idle(0);

    // Reset during DRIVE of k=2, then a clean sweep.
    mode[0] = 1;
    pulse_start(0, 1);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run(0, 0);

    // Start held high: back-to-back sweeps.
    mode[0] = 0;
    set_start(0, 1'b1);
    repeat (31) @(negedge clk);
    set_start(0, 1'b0);
    wait_idle(0);

    run(1, 0);  // SETTLE=3, OR
    run(1, 1);
    run(1, 4);

    for (int it = 0; it < 30; it++) begin
      int i, l;
      i = int'($urandom % 2);
      l = 4 * (settle(i) + 1);
      mode[i] = int'($urandom % 6);
      pulse_start(i, 1 + int'($urandom % 3));
      if ($urandom % 3 == 0) begin
        repeat (int'($urandom % l)) @(negedge clk);
        pulse_start(i, 1);
      end
      if ($urandom % 4 == 0) begin
        repeat (int'($urandom % l)) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      wait_idle(0);
      wait_idle(1);
    end

    repeat (2) @(negedge clk);
    check("sb_drained", 0, 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gate_seq_checker.md
GATE_SEQ_CHECKER -- requirements
Module: gate_seq_checker

Interface
REQ-001 The block SHALL have parameter SETTLE, default 1, meaning extra cycles each vector is held before op is sampled (legal range 1..15).
REQ-002 The block SHALL have parameter EXPECTED, default 4'b1110, meaning the expected op value for vector index k at bit k (default = 2-input OR).
REQ-003 The block SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 The block SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 The block SHALL have port start  input  1  request to run one truth-table sweep; sampled only in IDLE.
REQ-006 The block SHALL have port input1  output  1  first operand driven to the gate under test.
REQ-007 The block SHALL have port input2  output  1  second operand driven to the gate under test.
REQ-008 The block SHALL have port op  input  1  gate-under-test output.
REQ-009 The block SHALL have port busy  output  1  high while a sweep is in progress (DRIVE or SAMPLE).
REQ-010 The block SHALL have port done  output  1  one-cycle pulse when a sweep completes.
REQ-011 The block SHALL have port pass  output  1  high when the last completed sweep had zero mismatches.
REQ-012 The block SHALL have port fail_mask  output  4  bit k set when vector k mismatched in the current or last sweep.

Function
REQ-013 The block SHALL implement FSM states IDLE, DRIVE, SAMPLE and DONE, with a 2-bit vector index k and a 4-bit settle counter.
REQ-014 The block SHALL apply vector order k=0..3 as (input1,input2) = (0,0), (1,0), (0,1), (1,1), i.e. input1=k[0] and input2=k[1].
REQ-015 In IDLE the block SHALL drive input1=input2=0 and busy=0, and hold pass and fail_mask at their last values.
REQ-016 On start=1 in IDLE the block SHALL move to DRIVE with k=0, clear fail_mask to 0000, clear pass to 0, and load the settle counter.
REQ-017 The block SHALL remain in DRIVE for SETTLE cycles and then move to SAMPLE for exactly one cycle.
REQ-018 At the clock edge ending SAMPLE, the block SHALL set fail_mask[k] when op != EXPECTED[k], holding input1/input2 stable for the full DRIVE+SAMPLE span.
REQ-019 After SAMPLE, the block SHALL move to DRIVE with k+1 when k<3, and to DONE when k=3 (k does not wrap).
REQ-020 In DONE the block SHALL assert done=1 for one cycle, set pass=1 when fail_mask is 0000 (including the final sample), and return to IDLE.
REQ-021 For start sampled at edge E0, done SHALL be high in the cycle following edge E0+4*(SETTLE+1); with SETTLE=1 this is the cycle after E8.
REQ-022 The block SHALL ignore start while in DRIVE, SAMPLE or DONE, with no restart and no queued request.
REQ-023 With start held high continuously, a new sweep SHALL begin at the first IDLE cycle after DONE.
REQ-024 The block SHALL sample op only at the SAMPLE edge; op changes at any other time SHALL have no effect.

Reset
REQ-025 When rst=1 at a clock edge, the block SHALL enter IDLE with k=0, input1=0, input2=0, busy=0, done=0, pass=0 and fail_mask=0000.
REQ-026 rst SHALL take priority over start and over any in-progress sweep; reset mid-sweep SHALL abandon the sweep with no done pulse.
REQ-027 The first sweep after reset SHALL behave identically to any later sweep.

Verification
REQ-028 The bench SHALL cover this case: correct OR model on op, SETTLE=1, start pulse -> vectors 00,10,01,11 in order, each held 2 cycles; done after 8 cycles; pass=1; fail_mask=0000.
REQ-029 The bench SHALL cover this case: op tied 0 -> fail_mask=1110, pass=0; op tied 1 -> fail_mask=0001, pass=0.
REQ-030 The bench SHALL cover this case: AND model on op with default EXPECTED -> fail_mask=0110, pass=0, done single-cycle pulse.
REQ-031 The bench SHALL cover this case: start re-pulsed during SAMPLE of k=1 -> ignored; sweep completes normally; exactly one done pulse.
REQ-032 The bench SHALL cover this case: rst asserted during DRIVE k=2 -> next cycle IDLE, all outputs 0, no done; a following start gives a full clean sweep.
REQ-033 The bench SHALL cover this case: SETTLE=3, correct OR -> each vector held 4 cycles; done after 16 cycles; pass=1.
